// File: rtl/mach_dem_xuong_4bit.sv
// rtl/mach_dem_xuong_4bit.sv - loadable down counter with auto-reload / one-shot modes
// Registered terminal-count pulse; busy reflects the RUN state.
module mach_dem_xuong_4bit #(
   parameter int unsigned           WIDTH          = 4,
   parameter logic [WIDTH-1:0]      RELOAD_DEFAULT = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rs,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             oneshot,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy
);

   typedef enum logic {RUN = 1'b0, STOP = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rl_q, rl_d;
   logic             tc_q, tc_d;

   always_ff @(posedge clk or posedge rs) begin
      if (rs) begin
         state_q <= RUN;
         cnt_q   <= RELOAD_DEFAULT;
         rl_q    <= RELOAD_DEFAULT;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rl_q    <= rl_d;
         tc_q    <= tc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rl_d    = rl_q;
      tc_d    = 1'b0;
      if (load) begin
         // load wins over counting and is the only exit from STOP
         cnt_d   = d;
         rl_d    = d;
         state_d = RUN;
      end else if (state_q == RUN && en) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            tc_d  = (cnt_q == {{(WIDTH-1){1'b0}}, 1'b1});
         end else if (!oneshot) begin
            cnt_d = rl_q;
            tc_d  = (rl_q == '0);
         end else begin
            state_d = STOP;
         end
      end
   end

   assign q    = cnt_q;
   assign tc   = tc_q;
   assign busy = (state_q == RUN);

endmodule

// File: tb/tb_mach_dem_xuong_4bit.sv
// tb/tb_mach_dem_xuong_4bit.sv - self-checking bench for mach_dem_xuong_4bit
// Directed scenarios followed by randomized traffic against an arithmetic reference model.
module tb_mach_dem_xuong_4bit;

   logic       clk = 1'b0;
   logic       rs = 1'b0;
   logic       en = 1'b0;
   logic       load = 1'b0;
   logic [3:0] d = 4'h0;
   logic       oneshot = 1'b0;
   logic [3:0] q;
   logic       tc;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int m_q, m_rl, m_tc;
   bit m_stop;

   mach_dem_xuong_4bit dut (
      .clk(clk), .rs(rs), .en(en), .load(load), .d(d),
      .oneshot(oneshot), .q(q), .tc(tc), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q = 15; m_rl = 15; m_tc = 0; m_stop = 1'b0;
   endtask

   task automatic model_edge();
      if (load) begin
         m_q = int'(d); m_rl = int'(d); m_stop = 1'b0; m_tc = 0;
      end else if (!m_stop && en) begin
         if (m_q == 0 && oneshot) begin
            m_stop = 1'b1;
            m_tc   = 0;
         end else begin
            m_q  = (m_q == 0) ? m_rl : m_q - 1;
            m_tc = (m_q == 0) ? 1 : 0;
         end
      end else begin
         m_tc = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".q"}, int'(q), m_q);
      chk({tag, ".tc"}, int'(tc), m_tc);
      chk({tag, ".busy"}, int'(busy), m_stop ? 0 : 1);
   endtask

   task automatic step(input string tag, input logic l, input logic e,
                       input logic o, input logic [3:0] dv);
      load = l; en = e; oneshot = o; d = dv;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      int tcs;
      // reset asserted asynchronously before any clock edge
      #1 rs = 1'b1;
      model_reset();
      #1 check_all("reset");
      @(negedge clk);
      rs = 1'b0;

      // 1: free run from F with auto-reload
      tcs = 0;
      for (int i = 0; i < 34; i++) begin
         step("t1", 1'b0, 1'b1, 1'b0, 4'h0);
         tcs += int'(tc);
      end
      chk("t1.tc_count", tcs, 2);

      // 2: divide by 6
      step("t2.load", 1'b1, 1'b1, 1'b0, 4'h5);
      tcs = 0;
      for (int i = 0; i < 18; i++) begin
         step("t2", 1'b0, 1'b1, 1'b0, 4'h0);
         tcs += int'(tc);
      end
      chk("t2.tc_count", tcs, 3);

      // 3: one-shot from 3, then reload 2
      step("t3.load", 1'b1, 1'b1, 1'b1, 4'h3);
      tcs = 0;
      for (int i = 0; i < 7; i++) begin
         step("t3", 1'b0, 1'b1, 1'b1, 4'h0);
         tcs += int'(tc);
      end
      chk("t3.tc_count", tcs, 1);
      chk("t3.stopped", int'(busy), 0);
      step("t3.reload", 1'b1, 1'b0, 1'b1, 4'h2);
      for (int i = 0; i < 3; i++) step("t3b", 1'b0, 1'b1, 1'b1, 4'h0);

      // 4: enable gaps, load beats enable
      step("t4.load7", 1'b1, 1'b1, 1'b0, 4'h7);
      for (int i = 0; i < 3; i++) step("t4.hold", 1'b0, 1'b0, 1'b0, 4'h0);
      chk("t4.q_held", int'(q), 7);
      step("t4.loadA", 1'b1, 1'b1, 1'b0, 4'hA);
      chk("t4.q_A", int'(q), 10);
      step("t4.dec", 1'b0, 1'b1, 1'b0, 4'h0);
      chk("t4.q_9", int'(q), 9);

      // 5: asynchronous reset mid-count, with a load pending
      step("t5.load8", 1'b1, 1'b1, 1'b0, 4'h8);
      step("t5", 1'b0, 1'b1, 1'b0, 4'h0);
      step("t5", 1'b0, 1'b1, 1'b0, 4'h0);
      chk("t5.q_6", int'(q), 6);
      load = 1'b1; d = 4'h3;
      #4 rs = 1'b1;
      model_reset();
      #1 check_all("t5.async");
      #2 rs = 1'b0;
      step("t5.after", 1'b0, 1'b1, 1'b0, 4'h0);
      chk("t5.q_E", int'(q), 14);

      // 6: divide by 1
      step("t6.load0", 1'b1, 1'b1, 1'b0, 4'h0);
      for (int i = 0; i < 4; i++) begin
         step("t6", 1'b0, 1'b1, 1'b0, 4'h0);
         chk("t6.tc_hi", int'(tc), 1);
      end
      step("t6.en0", 1'b0, 1'b0, 1'b0, 4'h0);
      chk("t6.tc_lo", int'(tc), 0);

      // one-shot load of zero: straight to STOP without tc
      step("t6.os0", 1'b1, 1'b1, 1'b1, 4'h0);
      step("t6.os_stop", 1'b0, 1'b1, 1'b1, 4'h0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 60) == 0) begin
            #3 rs = 1'b1;
            model_reset();
            #1 check_all("rnd.rst");
            @(negedge clk);
            rs = 1'b0;
         end
         step("rnd", ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
